dmac_channel_arbiter: RTL and testbench

//  Shares the single AHB master port between N_CH DMA channel controllers.

---
 rtl/dmac_channel_arbiter.sv | 129 ++++++++++++
 tb/tb_dmac_channel_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_channel_arbiter.sv
// Round-robin grant sequencer sharing one AHB master port between DMA channels,
// with quantum-limited tenures and sticky, maskable completion interrupts.
module dmac_channel_arbiter #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned QUANTUM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH-1:0]         ch_burst_done,
    input  logic [N_CH-1:0]         ch_done,
    input  logic [N_CH-1:0]         irq_mask,
    input  logic [N_CH-1:0]         irq_clr,
    output logic [N_CH-1:0]         ch_grant,
    output logic [$clog2(N_CH)-1:0] grant_id,
    output logic                    grant_valid,
    output logic [N_CH-1:0]         irq_status,
    output logic                    dmac_irq
);

    localparam int unsigned IdW = $clog2(N_CH);

    typedef enum logic [1:0] {StIdle, StArb, StGranted, StRelease} state_e;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   ch_grant_q, ch_grant_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;
    logic [IdW-1:0]    last_ptr_q, last_ptr_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [N_CH-1:0]   irq_status_q, irq_status_d;

    logic              arb_found;
    logic [IdW-1:0]    arb_idx;
    logic [IdW-1:0]    cand;
    logic              g_req, g_done, g_burst;
    logic              others_req;
    logic              quantum_hit;
    logic              g_release;

    // Search last_ptr+1 .. last_ptr+N_CH; modulo keeps non-power-of-2 counts in range.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = IdW'((32'(last_ptr_q) + i) % N_CH);
            if (!arb_found && ch_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign g_req       = ch_req[grant_id_q];
    assign g_done      = ch_done[grant_id_q];
    assign g_burst     = ch_burst_done[grant_id_q];
    assign others_req  = |(ch_req & ~ch_grant_q);
    assign quantum_hit = ({1'b0, burst_cnt_q} + 5'd1) >= 5'(QUANTUM);
    // Done wins over burst-done; quantum expiry only yields to a waiting channel.
    assign g_release   = g_done || !g_req || (g_burst && quantum_hit && others_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (|ch_req) state_d = StArb;
            StArb:     state_d = arb_found ? StGranted : StIdle;
            StGranted: if (g_release) state_d = StRelease;
            StRelease: state_d = (|ch_req) ? StArb : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ch_grant_d   = ch_grant_q;
        grant_id_d   = grant_id_q;
        last_ptr_d   = last_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        irq_status_d = (irq_status_q & ~irq_clr) | ch_done;
        unique case (state_q)
            StArb: begin
                if (arb_found) begin
                    ch_grant_d  = N_CH'(1) << arb_idx;
                    grant_id_d  = arb_idx;
                    last_ptr_d  = arb_idx;
                    burst_cnt_d = '0;
                end
            end
            StGranted: begin
                if (g_release) begin
                    ch_grant_d = '0;
                end else if (g_burst) begin
                    burst_cnt_d = quantum_hit ? 4'(QUANTUM) : burst_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_grant_q   <= '0;
            grant_id_q   <= '0;
            last_ptr_q   <= IdW'(N_CH - 1);
            burst_cnt_q  <= '0;
            irq_status_q <= '0;
        end else begin
            ch_grant_q   <= ch_grant_d;
            grant_id_q   <= grant_id_d;
            last_ptr_q   <= last_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            irq_status_q <= irq_status_d;
        end
    end

    assign ch_grant    = ch_grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |ch_grant_q;
    assign irq_status  = irq_status_q;
    assign dmac_irq    = |(irq_status_q & irq_mask);

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// Directed bench for dmac_channel_arbiter (N_CH=4, QUANTUM=4): one task per scenario,
// inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_dmac_channel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_req, ch_burst_done, ch_done, irq_mask, irq_clr;
    logic [3:0] ch_grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [3:0] irq_status;
    logic       dmac_irq;

    int tests = 0;
    int fails = 0;

    dmac_channel_arbiter #(.N_CH(4), .QUANTUM(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_req        (ch_req),
        .ch_burst_done (ch_burst_done),
        .ch_done       (ch_done),
        .irq_mask      (irq_mask),
        .irq_clr       (irq_clr),
        .ch_grant      (ch_grant),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .irq_status    (irq_status),
        .dmac_irq      (dmac_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_req = '0; ch_burst_done = '0; ch_done = '0; irq_mask = '0; irq_clr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ch_req = '0; ch_burst_done = '0; ch_done = '0; irq_mask = '1; irq_clr = '0;
        rst = 1'b1;
        step();
        tests++;
        if (ch_grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_grant: grant=%b id=%0d valid=%b expected 0000/0/0",
                     ch_grant, grant_id, grant_valid);
        end
        tests++;
        if (irq_status !== 4'b0000 || dmac_irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_irq: status=%b irq=%b expected 0000/0", irq_status, dmac_irq);
        end
        rst = 1'b0;
        irq_mask = '0;
    endtask

    task automatic test_single_requester();
        do_reset();
        ch_req = 4'b0100;
        step();
        tests++;
        if (ch_grant !== 4'b0000) begin
            fails++;
            $display("FAIL single_arb_gap: grant=%b expected 0000", ch_grant);
        end
        step();
        tests++;
        if (ch_grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: grant=%b id=%0d valid=%b expected 0100/2/1",
                     ch_grant, grant_id, grant_valid);
        end
        for (int p = 0; p < 10; p++) begin
            ch_burst_done = 4'b0100;
            step();
            ch_burst_done = '0;
            tests++;
            if (ch_grant !== 4'b0100) begin
                fails++;
                $display("FAIL single_hold[%0d]: grant=%b expected 0100", p, ch_grant);
            end
        end
        // Saturated count: one more burst with a rival waiting forces release.
        ch_req = 4'b0101;
        ch_burst_done = 4'b0100;
        step();
        ch_burst_done = '0;
        tests++;
        if (ch_grant !== 4'b0000) begin
            fails++;
            $display("FAIL single_saturated_release: grant=%b expected 0000", ch_grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        ch_req = 4'b1111;
        step();
        step();
        for (int t = 0; t < 5; t++) begin
            exp = 4'b0001 << (t % 4);
            tests++;
            if (ch_grant !== exp || grant_id !== 2'(t % 4)) begin
                fails++;
                $display("FAIL rr_grant[%0d]: grant=%b id=%0d expected %b/%0d",
                         t, ch_grant, grant_id, exp, t % 4);
            end
            for (int p = 1; p <= 4; p++) begin
                ch_burst_done = exp;
                step();
                ch_burst_done = '0;
                tests++;
                if (ch_grant !== ((p < 4) ? exp : 4'b0000)) begin
                    fails++;
                    $display("FAIL rr_burst[%0d.%0d]: grant=%b expected %b",
                             t, p, ch_grant, (p < 4) ? exp : 4'b0000);
                end
            end
            step();
            tests++;
            if (ch_grant !== 4'b0000) begin
                fails++;
                $display("FAIL rr_gap[%0d]: grant=%b expected 0000", t, ch_grant);
            end
            step();
        end
    endtask

    task automatic test_completion();
        do_reset();
        ch_req = 4'b0010;
        irq_mask = 4'b0010;
        step();
        step();
        tests++;
        if (ch_grant !== 4'b0010) begin
            fails++;
            $display("FAIL done_grant: grant=%b expected 0010", ch_grant);
        end
        ch_done = 4'b0010;
        step();
        ch_done = '0;
        tests++;
        if (irq_status !== 4'b0010 || dmac_irq !== 1'b1 || ch_grant !== 4'b0000) begin
            fails++;
            $display("FAIL done_set: status=%b irq=%b grant=%b expected 0010/1/0000",
                     irq_status, dmac_irq, ch_grant);
        end
        irq_mask = 4'b1101;
        #1;
        tests++;
        if (dmac_irq !== 1'b0) begin
            fails++;
            $display("FAIL done_masked: irq=%b expected 0", dmac_irq);
        end
        irq_mask = 4'b0010;
        ch_req = '0;
        irq_clr = 4'b0010;
        step();
        irq_clr = '0;
        tests++;
        if (irq_status !== 4'b0000 || dmac_irq !== 1'b0) begin
            fails++;
            $display("FAIL done_clear: status=%b irq=%b expected 0000/0", irq_status, dmac_irq);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        ch_done = 4'b0100;
        irq_clr = 4'b0100;
        step();
        ch_done = '0;
        irq_clr = '0;
        tests++;
        if (irq_status !== 4'b0100) begin
            fails++;
            $display("FAIL set_wins: status=%b expected 0100", irq_status);
        end
        irq_clr = 4'b0100;
        step();
        irq_clr = '0;
        tests++;
        if (irq_status !== 4'b0000) begin
            fails++;
            $display("FAIL clear_only: status=%b expected 0000", irq_status);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        ch_req = 4'b1000;
        step();
        step();
        tests++;
        if (ch_grant !== 4'b1000 || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL drop_grant: grant=%b id=%0d expected 1000/3", ch_grant, grant_id);
        end
        ch_req = 4'b1001;
        ch_burst_done = 4'b1000;
        step();
        ch_burst_done = '0;
        for (int p = 0; p < 4; p++) begin
            ch_burst_done = 4'b0001;
            step();
        end
        ch_burst_done = '0;
        tests++;
        if (ch_grant !== 4'b1000) begin
            fails++;
            $display("FAIL drop_ignore_other: grant=%b expected 1000", ch_grant);
        end
        ch_req = 4'b0001;
        step();
        tests++;
        if (ch_grant !== 4'b0000) begin
            fails++;
            $display("FAIL drop_release: grant=%b expected 0000", ch_grant);
        end
        step();
        step();
        tests++;
        if (ch_grant !== 4'b0001 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL drop_next: grant=%b id=%0d expected 0001/0", ch_grant, grant_id);
        end
        ch_req = '0;
        step();
        step();
        step();
        tests++;
        if (ch_grant !== 4'b0000 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_idle: grant=%b valid=%b expected 0000/0", ch_grant, grant_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ch_req = 4'b0001;
        step();
        step();
        for (int p = 0; p < 2; p++) begin
            ch_burst_done = 4'b0001;
            step();
        end
        ch_burst_done = '0;
        tests++;
        if (ch_grant !== 4'b0001) begin
            fails++;
            $display("FAIL arst_pre: grant=%b expected 0001", ch_grant);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (ch_grant !== 4'b0000 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL arst_immediate: grant=%b valid=%b expected 0000/0",
                     ch_grant, grant_valid);
        end
        step();
        rst = 1'b0;
        ch_req = 4'b1000;
        step();
        tests++;
        if (ch_grant !== 4'b0000) begin
            fails++;
            $display("FAIL arst_arb_gap: grant=%b expected 0000", ch_grant);
        end
        step();
        tests++;
        if (ch_grant !== 4'b1000 || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL arst_regrant: grant=%b id=%0d expected 1000/3", ch_grant, grant_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_completion();
        test_set_clear();
        test_req_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
